// File: rtl/cond_flag_evaluator_pkg.sv
// Shared types for the comparator-flag consumer: condition codes, the flag pair, and condition evaluation.
package cond_eval_pkg;

    typedef enum logic [2:0] {EQ, NE, GT, GE, LT, LE, ALWAYS, NEVER} cond_e;

    typedef struct packed {
        logic gt;
        logic eq;
    } flag_t;

    // lt is implied: a pair with neither gt nor eq means a < b.
    function automatic logic eval(cond_e c, flag_t f);
        logic lt;
        logic r;
        lt = !f.gt && !f.eq;
        case (c)
            EQ:      r = f.eq;
            NE:      r = !f.eq;
            GT:      r = f.gt;
            GE:      r = f.gt | f.eq;
            LT:      r = lt;
            LE:      r = lt | f.eq;
            ALWAYS:  r = 1'b1;
            NEVER:   r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cond_flag_evaluator_fifo.sv
// Small synchronous FIFO for comparator flag pairs; head entry is visible combinationally on rdata_o.
module flag_fifo
    import cond_eval_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = flag_t
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           wr_en_i,
    input  entry_t                         wdata_i,
    input  logic                           rd_en_i,
    output entry_t                         rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           full_o,
    output logic                           empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_wr, do_rd;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/cond_flag_evaluator.sv
// Buffers comparator flag pairs and answers condition queries with a registered taken bit.
// Optional COND_FLAG_CHECK_EN drops illegal {gt,eq}={1,1} pushes and raises a sticky flag_err.
module cond_flag_evaluator
    import cond_eval_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flag_valid,
    output logic                        flag_ready,
    input  logic                        is_a_greater,
    input  logic                        equal,
    input  logic                        query_valid,
    output logic                        query_ready,
    input  cond_e                       cond,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic                        taken,
    output logic [$clog2(DEPTH+1)-1:0]  flag_count,
    output logic                        flag_err
);

    flag_t  wdata, head;
    logic   push, pop, wr_en;
    logic   full, empty;
    logic   res_valid_q, res_valid_d;
    logic   taken_q, taken_d;

    assign wdata.gt    = is_a_greater;
    assign wdata.eq    = equal;
    assign flag_ready  = !full;
    assign query_ready = !empty && (!res_valid_q || res_ready);
    assign push        = flag_valid && flag_ready;
    assign pop         = query_valid && query_ready;
    assign res_valid   = res_valid_q;
    assign taken       = taken_q;

`ifdef COND_FLAG_CHECK_EN
    logic illegal;
    logic flag_err_q;

    assign illegal  = is_a_greater && equal;
    assign wr_en    = push && !illegal;
    assign flag_err = flag_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n)               flag_err_q <= 1'b0;
        else if (push && illegal) flag_err_q <= 1'b1;
    end
`else
    assign wr_en    = push;
    assign flag_err = 1'b0;
`endif

    flag_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (flag_t)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .wr_en_i (wr_en),
        .wdata_i (wdata),
        .rd_en_i (pop),
        .rdata_o (head),
        .count_o (flag_count),
        .full_o  (full),
        .empty_o (empty)
    );

    // A drained result keeps its last taken value; only res_valid drops.
    always_comb begin
        res_valid_d = res_valid_q;
        taken_d     = taken_q;
        if (pop) begin
            res_valid_d = 1'b1;
            taken_d     = eval(cond, head);
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            taken_q     <= 1'b0;
        end else begin
            res_valid_q <= res_valid_d;
            taken_q     <= taken_d;
        end
    end

endmodule
